relax_freq_counter: RTL and testbench
=====================================

RELAX_FREQ_COUNTER -- requirements
Module: relax_freq_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the edge count and result.
REQ-002 SHALL have parameter GATE_W, default 16, width of the gate-length input and gate timer.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on osc_in (minimum 2).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port osc_in, input, 1, asynchronous relaxation-oscillator output, taken from an input pin.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin a measurement.
REQ-008 SHALL have port continuous, input, 1, when 1, a new gate starts automatically after each result.
REQ-009 SHALL have port gate_len, input, GATE_W, gate window length in clk cycles, sampled at gate start.
REQ-010 SHALL have port count, output, CNT_W, last latched edge count.
REQ-011 SHALL have port valid, output, 1, one-cycle pulse when count updates.
REQ-012 SHALL have port busy, output, 1, high while in GATE or DONE.
REQ-013 SHALL have port overflow, output, 1, sticky for the latched result: edge count saturated.

Function
REQ-014 SHALL pass osc_in through SYNC_STAGES flops, then derive edge_p = synced & ~synced_d (rising edges only).
REQ-015 SHALL implement the FSM states IDLE, GATE and DONE.
REQ-016 IDLE -> GATE on start: load timer with max(gate_len,1), clear the edge counter and the overflow accumulator.
REQ-017 GATE SHALL last exactly max(gate_len,1) cycles, decrementing the timer each cycle and counting every edge_p cycle.
REQ-018 The edge counter SHALL saturate at 2^CNT_W-1; an edge arriving at saturation SHALL set the overflow accumulator.
REQ-019 GATE -> DONE after the last gate cycle; an edge_p in that last cycle SHALL be counted.
REQ-020 In DONE (one cycle), count and overflow SHALL be latched and valid SHALL pulse high in the same cycle.
REQ-021 DONE -> GATE if continuous=1 (reloading gate_len, with no dead cycle besides DONE), else DONE -> IDLE.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 The edge latency from an osc_in rising edge to its count increment SHALL be SYNC_STAGES+1 cycles; edges still in the synchronizer at gate end belong to the next gate.
REQ-024 count and overflow SHALL hold their values between valid pulses.
REQ-025 A change of gate_len during GATE SHALL have no effect until the next gate start.

Reset
REQ-026 rst SHALL force the FSM to IDLE and clear the synchronizer flops, timer, edge counter, count, overflow, valid and busy to 0.
REQ-027 rst asserted mid-GATE SHALL discard the partial measurement with no valid pulse; the first start after reset release SHALL be honoured.

Structure
REQ-028 A shared package relax_osc_pkg SHALL hold the FSM state enum and the default CNT_W, GATE_W and SYNC_STAGES constants.
REQ-029 The synchronizer and edge detector SHALL be one sub-module, relax_sync_edge (parameter SYNC_STAGES, ports clk, rst, async_in, edge_p).
REQ-030 The implementation SHALL need no other sub-modules; target size is 120-400 RTL lines.

Verification
REQ-031 Period check: osc_in period 10 clk, gate_len=100, start pulse -> one valid, count=10 (±1), overflow=0.
REQ-032 Saturation: CNT_W=4, osc_in period 4 clk, gate_len=200 -> count=15, overflow=1.
REQ-033 Minimum gate: gate_len=0 -> gate lasts 1 cycle, valid 2 cycles after start, count is 0 or 1.
REQ-034 Continuous mode: continuous=1, gate_len=50, period 5 -> valid every 51 cycles, each count=10 (±1); start pulses while busy are ignored.
REQ-035 Reset mid-gate: rst asserted at gate cycle 30 of 100 -> no valid pulse, all outputs 0 next cycle; a following start gives a correct full measurement.
REQ-036 Idle osc_in: constant osc_in=1, gate_len=64 -> count=0, overflow=0.

Source files
------------

// File: rtl/relax_osc_pkg.sv
// Shared definitions for the relaxation-oscillator frequency counter:
// default widths, synchronizer depth and the measurement FSM state type.
package relax_osc_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_GATE_W      = 16;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/relax_sync_edge.sv
// Brings the asynchronous oscillator pin into the clk domain through a
// flop chain and emits a one-cycle pulse for each rising edge seen.
module relax_sync_edge
    import relax_osc_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_p
);

    // Fewer than two flops gives no metastability protection, so clamp.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              synced_dly_q;
    logic              synced_dly_d;

    // Stage 0 captures the raw pin; every later stage copies its predecessor.
    assign sync_d[0] = async_in;
    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    // Delayed copy of the synchronized level, used to spot the 0->1 change.
    always_comb begin
        synced_dly_d = sync_q[STAGES-1];
    end

    // Synchronizer chain and edge-detect history, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            synced_dly_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            synced_dly_q <= synced_dly_d;
        end
    end

    assign edge_p = sync_q[STAGES-1] & ~synced_dly_q;

endmodule

// File: rtl/relax_freq_counter.sv
// Gated frequency counter for a relaxation oscillator: counts synchronized
// rising edges over a programmable window of clk cycles and publishes the
// saturated count plus an overflow flag with a one-cycle valid pulse.
module relax_freq_counter
    import relax_osc_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GATE_W      = DEF_GATE_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              osc_in,
    input  logic              start,
    input  logic              continuous,
    input  logic [GATE_W-1:0] gate_len,
    output logic [CNT_W-1:0]  count,
    output logic              valid,
    output logic              busy,
    output logic              overflow
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

    state_e            state_q;
    state_e            state_d;
    logic [GATE_W-1:0] timer_q;
    logic [GATE_W-1:0] timer_d;
    logic [CNT_W-1:0]  edge_cnt_q;
    logic [CNT_W-1:0]  edge_cnt_d;
    logic              ovf_acc_q;
    logic              ovf_acc_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              overflow_q;
    logic              overflow_d;
    logic              valid_q;
    logic              valid_d;
    logic              busy_q;
    logic              busy_d;

    logic              edge_p;
    logic [CNT_W-1:0]  cnt_inc;
    logic              ovf_inc;

    // A zero-length gate is stretched to one cycle so a measurement always ends.
    function automatic logic [GATE_W-1:0] gate_load(input logic [GATE_W-1:0] len);
        return (len == '0) ? GATE_ONE : len;
    endfunction

    relax_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .async_in (osc_in),
        .edge_p   (edge_p)
    );

    // Saturating edge accumulation: an edge at full scale only raises overflow.
    always_comb begin
        cnt_inc = edge_cnt_q;
        ovf_inc = ovf_acc_q;
        if (edge_p) begin
            if (edge_cnt_q == CNT_MAX) begin
                ovf_inc = 1'b1;
            end else begin
                cnt_inc = edge_cnt_q + CNT_ONE;
            end
        end
    end

    // Measurement sequencing: IDLE waits for start, GATE counts edges while
    // the timer runs down, DONE is the single publish cycle.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        edge_cnt_d = edge_cnt_q;
        ovf_acc_d  = ovf_acc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_GATE;
                    timer_d    = gate_load(gate_len);
                    edge_cnt_d = '0;
                    ovf_acc_d  = 1'b0;
                end
            end

            ST_GATE: begin
                edge_cnt_d = cnt_inc;
                ovf_acc_d  = ovf_inc;
                timer_d    = timer_q - GATE_ONE;
                // Last gate cycle: publish including any edge seen right now,
                // so count/overflow change on the same edge valid rises.
                if (timer_q == GATE_ONE) begin
                    state_d    = ST_DONE;
                    count_d    = cnt_inc;
                    overflow_d = ovf_inc;
                    valid_d    = 1'b1;
                end
            end

            ST_DONE: begin
                // Back-to-back gates reload straight from DONE, so DONE is
                // the only cycle in which edges are not counted.
                if (continuous) begin
                    state_d    = ST_GATE;
                    timer_d    = gate_load(gate_len);
                    edge_cnt_d = '0;
                    ovf_acc_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, timer, accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            edge_cnt_q <= '0;
            ovf_acc_q  <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_acc_q  <= ovf_acc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign valid    = valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_relax_freq_counter.sv
// Randomized scoreboard bench for relax_freq_counter. Two instances share
// the stimulus: a 16-bit counter with a 2-flop synchronizer and a 4-bit
// counter with a 3-flop synchronizer (exercises saturation/overflow).
module tb_relax_freq_counter;

    localparam int GW  = 16;
    localparam int N16 = 2;
    localparam int N4  = 3;
    localparam int NC  = 40000;

    typedef struct {
        int vcyc;
        int cnt;
        int ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          osc_in = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic [GW-1:0] gate_len = '0;

    logic [15:0] count16;
    logic        valid16, busy16, ovf16;
    logic [3:0]  count4;
    logic        valid4, busy4, ovf4;

    int   cyc = 0;
    bit   osc_bits [0:NC-1];
    exp_t q16[$];
    exp_t q4[$];
    int   checks = 0;
    int   errors = 0;
    int   last16 = 0, lovf16 = 0, last4 = 0, lovf4 = 0;

    relax_freq_counter #(.CNT_W(16), .GATE_W(GW), .SYNC_STAGES(N16)) u_dut16 (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .continuous(continuous),
        .gate_len(gate_len), .count(count16), .valid(valid16), .busy(busy16), .overflow(ovf16)
    );

    relax_freq_counter #(.CNT_W(4), .GATE_W(GW), .SYNC_STAGES(N4)) u_dut4 (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .continuous(continuous),
        .gate_len(gate_len), .count(count4), .valid(valid4), .busy(busy4), .overflow(ovf4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator pin follows the planned waveform, one level per clk cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            osc_in = (cyc < NC) ? osc_bits[cyc] : 1'b0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Square wave with the given period (high for period/2), period 0 = stuck high.
    task automatic plan_osc(input int period, input int phase);
        int hi;
        hi = (cyc + 4000 < NC) ? cyc + 4000 : NC - 1;
        for (int c = cyc + 1; c <= hi; c++) begin
            osc_bits[c] = (period == 0) ? 1'b1 : (((c + phase) % period) < (period / 2));
        end
    endtask

    // Reference: an osc rise in cycle c becomes a count event in cycle c+n;
    // count all such events that land inside the gate cycles [lo,hi].
    function automatic int exp_count(input int lo, input int hi, input int n);
        int k;
        k = 0;
        for (int c = lo - n; c <= hi - n; c++) begin
            if (c >= 1 && c < NC && osc_bits[c] && !osc_bits[c-1]) k++;
        end
        return k;
    endfunction

    // Start issued in cycle s: gate k covers leff cycles, result shows one cycle later.
    task automatic push_windows(input int s, input int L, input int nwin);
        int   leff, lo, hi, n;
        exp_t e;
        leff = (L == 0) ? 1 : L;
        for (int k = 0; k < nwin; k++) begin
            lo = s + 1 + k * (leff + 1);
            hi = lo + leff - 1;
            e.vcyc = hi + 1;
            n = exp_count(lo, hi, N16);
            e.cnt = (n > 65535) ? 65535 : n;
            e.ovf = (n > 65535) ? 1 : 0;
            q16.push_back(e);
            n = exp_count(lo, hi, N4);
            e.cnt = (n > 15) ? 15 : n;
            e.ovf = (n > 15) ? 1 : 0;
            q4.push_back(e);
            $display("txn: start@%0d gate_len=%0d window %0d..%0d expect16=%0d expect4=%0d/%0d",
                     s, L, lo, hi, q16[$].cnt, e.cnt, e.ovf);
        end
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q16.size() != 0 || q4.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout_pending", q16.size() + q4.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("busy16_idle", int'(busy16), 0);
        chk("busy4_idle", int'(busy4), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_count16"}, int'(count16), 0);
        chk({tag, "_valid16"}, int'(valid16), 0);
        chk({tag, "_busy16"}, int'(busy16), 0);
        chk({tag, "_ovf16"}, int'(ovf16), 0);
        chk({tag, "_count4"}, int'(count4), 0);
        chk({tag, "_valid4"}, int'(valid4), 0);
        chk({tag, "_busy4"}, int'(busy4), 0);
        chk({tag, "_ovf4"}, int'(ovf4), 0);
    endtask

    task automatic run_single(input int L, input bit stray);
        int s, leff;
        leff = (L == 0) ? 1 : L;
        @(posedge clk);
        #1;
        gate_len = GW'(L);
        start = 1'b1;
        s = cyc;
        push_windows(s, L, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (leff >= 4) begin
            wait_cycle(s + 2 + int'($urandom_range(0, leff - 3)));
            chk("busy16_gate", int'(busy16), 1);
            chk("busy4_gate", int'(busy4), 1);
            if (stray) begin
                start = 1'b1;
                gate_len = GW'($urandom_range(0, 500));
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        drain(leff + 20);
    endtask

    task automatic run_cont(input int L, input int nwin);
        int s, leff;
        leff = (L == 0) ? 1 : L;
        continuous = 1'b1;
        @(posedge clk);
        #1;
        gate_len = GW'(L);
        start = 1'b1;
        s = cyc;
        push_windows(s, L, nwin);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < nwin; k++) begin
            wait_cycle(s + 2 + k * (leff + 1));
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k == nwin - 1) continuous = 1'b0;
        end
        drain(nwin * (leff + 1) + 20);
    endtask

    initial begin
        int per, s, L;

        // Monitor: pops an expectation whenever an instance presents valid.
        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    q16.delete();
                    q4.delete();
                    last16 = 0; lovf16 = 0; last4 = 0; lovf4 = 0;
                end else begin
                    if (valid16) begin
                        if (q16.size() == 0) begin
                            chk("valid16_unexpected", 1, 0);
                        end else begin
                            exp_t e;
                            e = q16.pop_front();
                            chk("valid16_cycle", cyc, e.vcyc);
                            chk("count16", int'(count16), e.cnt);
                            chk("overflow16", int'(ovf16), e.ovf);
                            $display("result16 @%0d: count=%0d overflow=%0d", cyc, count16, ovf16);
                            last16 = e.cnt;
                            lovf16 = e.ovf;
                        end
                    end else begin
                        chk("hold_count16", int'(count16), last16);
                        chk("hold_ovf16", int'(ovf16), lovf16);
                    end
                    if (valid4) begin
                        if (q4.size() == 0) begin
                            chk("valid4_unexpected", 1, 0);
                        end else begin
                            exp_t e;
                            e = q4.pop_front();
                            chk("valid4_cycle", cyc, e.vcyc);
                            chk("count4", int'(count4), e.cnt);
                            chk("overflow4", int'(ovf4), e.ovf);
                            $display("result4  @%0d: count=%0d overflow=%0d", cyc, count4, ovf4);
                            last4 = e.cnt;
                            lovf4 = e.ovf;
                        end
                    end else begin
                        chk("hold_count4", int'(count4), last4);
                        chk("hold_ovf4", int'(ovf4), lovf4);
                    end
                end
            end
        join_none

        // Reset state.
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset");

        // Period 10 over a 100-cycle gate.
        plan_osc(10, 3);
        repeat (5) @(posedge clk);
        run_single(100, 1'b0);

        // Period 4 over 200 cycles saturates the 4-bit instance.
        plan_osc(4, 1);
        repeat (5) @(posedge clk);
        run_single(200, 1'b1);

        // Zero gate length behaves as a single-cycle gate.
        plan_osc(2, 0);
        repeat (5) @(posedge clk);
        run_single(0, 1'b0);
        run_single(1, 1'b0);

        // Stuck-high oscillator yields no edges.
        plan_osc(0, 0);
        repeat (10) @(posedge clk);
        run_single(64, 1'b1);

        // Continuous mode with stray start pulses.
        plan_osc(5, 2);
        repeat (5) @(posedge clk);
        run_cont(50, 4);

        // Reset in gate cycle 30 of 100 discards the measurement.
        plan_osc(7, 0);
        repeat (5) @(posedge clk);
        #1;
        gate_len = GW'(100);
        start = 1'b1;
        s = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_cycle(s + 30);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("midgate_reset");
        repeat (10) @(posedge clk);
        run_single(100, 1'b0);

        // Randomized transactions.
        for (int t = 0; t < 10; t++) begin
            per = int'($urandom_range(2, 40));
            plan_osc(per, int'($urandom_range(0, per - 1)));
            repeat (5) @(posedge clk);
            L = int'($urandom_range(0, 300));
            if ($urandom_range(0, 3) == 0 && L >= 3) begin
                run_cont(L, 2);
            end else begin
                run_single(L, 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
